// File: rtl/crc_lut_pkg.sv
// Shared types and constants for the byte-serial CRC lookup-table sequencer.
// CRC_LUT_SEQ_REG_TAB_EN adds the ISSUE/UPDATE sub-phase for a registered table.
package crc_lut_pkg;

  localparam int CRC_W  = 32;
  localparam int TAB_AW = 8;

  localparam logic [CRC_W-1:0] CRC_INIT_DEF    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_XOR_OUT_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef CRC_LUT_SEQ_REG_TAB_EN
  typedef enum logic {
    ISSUE  = 1'b0,
    UPDATE = 1'b1
  } phase_t;
`endif

endpackage

// File: rtl/crc_lut_seq.sv
// Byte-serial CRC sequencer driving an external 256x32 lookup table.
// Define CRC_LUT_SEQ_REG_TAB_EN when the table has a registered (1-cycle) read.
module crc_lut_seq
  import crc_lut_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT    = CRC_INIT_DEF,
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_XOR_OUT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic [1:0]       s_bytes,
  input  logic             s_last,
  output logic [31:0]      tab_addr,
  input  logic [CRC_W-1:0] tab_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CRC_W-1:0] m_crc,
  output logic             busy
);

  state_t             state;
  logic [CRC_W-1:0]   crc;
  logic [31:0]        word;
  logic [2:0]         nbytes;
  logic [1:0]         byte_idx;
  logic               last;
  logic               sof;

  logic [7:0]         cur_byte;
  logic [TAB_AW-1:0]  index;
  logic [CRC_W-1:0]   crc_next;
  logic               last_byte;
  logic               step_en;

`ifdef CRC_LUT_SEQ_REG_TAB_EN
  phase_t phase;
  // The table answers one cycle after the address, so only UPDATE consumes it.
  assign step_en = (phase == UPDATE);
`else
  assign step_en = 1'b1;
`endif

  always_comb begin
    cur_byte  = word[{byte_idx, 3'b000} +: 8];
    index     = crc[7:0] ^ cur_byte;
    crc_next  = (crc >> 8) ^ tab_rdata;
    last_byte = ({1'b0, byte_idx} == (nbytes - 3'd1));
  end

  // The index depends only on registered state, so it is stable for the whole RUN cycle.
  assign tab_addr = (state == RUN) ? {{(32 - TAB_AW){1'b0}}, index} : 32'd0;
  assign s_ready  = (state == IDLE);
  assign busy     = (state != IDLE) || !sof;

  // NOTE: every register here uses <= so all updates see the pre-edge values of crc/byte_idx.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      crc      <= INIT;
      sof      <= 1'b1;
      word     <= '0;
      nbytes   <= '0;
      byte_idx <= '0;
      last     <= 1'b0;
      m_valid  <= 1'b0;
      m_crc    <= '0;
`ifdef CRC_LUT_SEQ_REG_TAB_EN
      phase    <= ISSUE;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            word     <= s_data;
            nbytes   <= (s_bytes == 2'd0) ? 3'd4 : {1'b0, s_bytes};
            last     <= s_last;
            byte_idx <= '0;
            state    <= RUN;
`ifdef CRC_LUT_SEQ_REG_TAB_EN
            phase    <= ISSUE;
`endif
            if (sof) begin
              crc <= INIT;
              sof <= 1'b0;
            end
          end
        end
        RUN: begin
`ifdef CRC_LUT_SEQ_REG_TAB_EN
          phase <= (phase == ISSUE) ? UPDATE : ISSUE;
`endif
          if (step_en) begin
            crc      <= crc_next;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              if (last) begin
                state   <= DONE;
                m_valid <= 1'b1;
                m_crc   <= crc_next ^ XOR_OUT;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            crc     <= INIT;
            sof     <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_lut_seq.sv
// Directed bench for crc_lut_seq: a zero-INIT/XOR instance and a default instance
// share one stimulus bus; sel picks which one is driven and observed.
module tb_crc_lut_seq;

`ifdef CRC_LUT_SEQ_REG_TAB_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        s_valid, s_last, m_ready;
  logic [31:0] s_data;
  logic [1:0]  s_bytes;

  logic        a_s_ready, a_m_valid, a_busy;
  logic [31:0] a_tab_addr, a_tab_rdata, a_m_crc;
  logic        b_s_ready, b_m_valid, b_busy;
  logic [31:0] b_tab_addr, b_tab_rdata, b_m_crc;

  logic        s_ready, m_valid, busy;
  logic [31:0] tab_addr, m_crc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Entries quoted from the crctab golden table; others come from a reflected generator.
  function automatic logic [31:0] tab_fn(input logic [7:0] i);
    logic [31:0] c;
    case (i)
      8'h00:   c = 32'h0000_0000;
      8'h01:   c = 32'h47f7_cec1;
      8'h80:   c = 32'h6e87_f0b9;
      8'hC1:   c = 32'h9c53_48ff;
      8'hFF:   c = 32'h8a17_11fc;
      default: begin
        c = {24'd0, i};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    endcase
    return c;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] init, input logic [31:0] xo,
                                        input logic [31:0] d, input int n);
    logic [31:0] c;
    c = init;
    for (int i = 0; i < n; i++) c = (c >> 8) ^ tab_fn(c[7:0] ^ d[8*i +: 8]);
    return c ^ xo;
  endfunction

  function automatic int lat(input int n);
    return (STEP == 2) ? (2 * n + 1) : (n + 1);
  endfunction

`ifdef CRC_LUT_SEQ_REG_TAB_EN
  always @(posedge clk) begin
    a_tab_rdata <= tab_fn(a_tab_addr[7:0]);
    b_tab_rdata <= tab_fn(b_tab_addr[7:0]);
  end
`else
  always_comb begin
    a_tab_rdata = tab_fn(a_tab_addr[7:0]);
    b_tab_rdata = tab_fn(b_tab_addr[7:0]);
  end
`endif

  crc_lut_seq #(.INIT(32'h0), .XOR_OUT(32'h0)) u_zero (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid && !sel), .s_ready(a_s_ready), .s_data(s_data),
    .s_bytes(s_bytes), .s_last(s_last),
    .tab_addr(a_tab_addr), .tab_rdata(a_tab_rdata),
    .m_valid(a_m_valid), .m_ready(m_ready && !sel), .m_crc(a_m_crc), .busy(a_busy)
  );

  crc_lut_seq u_dflt (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid && sel), .s_ready(b_s_ready), .s_data(s_data),
    .s_bytes(s_bytes), .s_last(s_last),
    .tab_addr(b_tab_addr), .tab_rdata(b_tab_rdata),
    .m_valid(b_m_valid), .m_ready(m_ready && sel), .m_crc(b_m_crc), .busy(b_busy)
  );

  assign s_ready  = sel ? b_s_ready  : a_s_ready;
  assign m_valid  = sel ? b_m_valid  : a_m_valid;
  assign busy     = sel ? b_busy     : a_busy;
  assign tab_addr = sel ? b_tab_addr : a_tab_addr;
  assign m_crc    = sel ? b_m_crc    : a_m_crc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Presents one word, waits (bounded) for acceptance, returns at the first post-accept negedge.
  task automatic put(input logic [31:0] d, input logic [1:0] nb, input logic l, input string tag);
    int k;
    k = 0;
    s_data = d; s_bytes = nb; s_last = l; s_valid = 1'b1;
    while (s_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " accept"}, {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input logic [31:0] exp, input int exp_lat, input string tag);
    while (m_valid !== 1'b1 && cyc < 40) tick();
    chk({tag, " m_valid"}, {31'd0, m_valid}, 32'd1);
    chk({tag, " m_crc"}, m_crc, exp);
    chk({tag, " latency"}, cyc, exp_lat);
  endtask

  task automatic ack(input string tag);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, " m_valid cleared"}, {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp5;
    logic [31:0] exp6;
    rstn = 1'b0; sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    s_data = '0; s_bytes = '0;

    // Reset values on both instances.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      chk("rst s_ready",  {31'd0, s_ready}, 32'd1);
      chk("rst m_valid",  {31'd0, m_valid}, 32'd0);
      chk("rst m_crc",    m_crc, 32'd0);
      chk("rst tab_addr", tab_addr, 32'd0);
      chk("rst busy",     {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single byte 0x01, zero INIT/XOR.
    sel = 1'b0;
    put(32'h01, 2'd1, 1'b1, "t1");
    chk("t1 tab_addr", tab_addr, 32'd1);
    chk("t1 busy", {31'd0, busy}, 32'd1);
    wait_valid(32'h47f7_cec1, lat(1), "t1");
    ack("t1");

    // 2: single bytes 0x80 and 0xFF.
    put(32'h80, 2'd1, 1'b1, "t2a");
    wait_valid(32'h6e87_f0b9, lat(1), "t2a");
    ack("t2a");
    put(32'hFF, 2'd1, 1'b1, "t2b");
    wait_valid(32'h8a17_11fc, lat(1), "t2b");
    ack("t2b");

    // 3: default INIT/XOR, byte 0xFF indexes entry 0.
    sel = 1'b1;
    put(32'hFF, 2'd1, 1'b1, "t3");
    chk("t3 tab_addr", tab_addr, 32'd0);
    wait_valid(32'hFF00_0000, lat(1), "t3");
    ack("t3");

    // 4: two bytes in one word, then the same bytes split over two words.
    sel = 1'b0;
    put(32'h0001, 2'd2, 1'b1, "t4a");
    repeat (STEP) tick();
    chk("t4a second index", tab_addr, 32'hC1);
    wait_valid(32'h9c14_bf31, lat(2), "t4a");
    ack("t4a");
    chk("t4a busy after ack", {31'd0, busy}, 32'd0);
    put(32'h01, 2'd1, 1'b0, "t4b");
    repeat (STEP) tick();
    chk("t4b idle between words", {31'd0, s_ready}, 32'd1);
    chk("t4b frame open", {31'd0, busy}, 32'd1);
    put(32'h00, 2'd1, 1'b1, "t4c");
    wait_valid(32'h9c14_bf31, lat(1), "t4c");
    ack("t4c");

    // 5: stray m_ready ignored, back-pressure in DONE, restart from INIT.
    sel = 1'b1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t5 stray m_ready", {31'd0, m_valid}, 32'd0);
    exp5 = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h12, 1);
    put(32'h12, 2'd1, 1'b1, "t5a");
    wait_valid(exp5, lat(1), "t5a");
    s_data = 32'hFF; s_bytes = 2'd1; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5 hold m_valid", {31'd0, m_valid}, 32'd1);
      chk("t5 hold m_crc",   m_crc, exp5);
      chk("t5 hold s_ready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;
    ack("t5a");
    put(32'hFF, 2'd1, 1'b1, "t5b");
    wait_valid(32'hFF00_0000, lat(1), "t5b");
    ack("t5b");

    // 6: reset in the middle of a 4-byte non-last word, then a clean frame.
    put(32'h1234_5678, 2'd0, 1'b0, "t6a");
    tick();
    chk("t6 busy before reset", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6 rst s_ready",  {31'd0, s_ready}, 32'd1);
    chk("t6 rst m_valid",  {31'd0, m_valid}, 32'd0);
    chk("t6 rst m_crc",    m_crc, 32'd0);
    chk("t6 rst tab_addr", tab_addr, 32'd0);
    chk("t6 rst busy",     {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    exp6 = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 4);
    put(32'h1234_5678, 2'd0, 1'b1, "t6b");
    wait_valid(exp6, lat(4), "t6b");
    ack("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_lut_seq.md
Name: crc_lut_seq

Overview:
Byte-serial sequencer for the 256x32 CRC lookup table (crctab_*). It accepts 32-bit data words over a valid/ready stream and issues one table lookup per byte. It accumulates the CRC over a frame and presents the final CRC on a valid/ready result port. The table is instantiated outside this block, alongside it.

Parameters:
- INIT, 32'hFFFFFFFF, CRC register value loaded at the start of each frame.
- XOR_OUT, 32'hFFFFFFFF, value XORed into the CRC register to form m_crc.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  32  data word; byte 0 = s_data[7:0] is processed first.
- s_bytes  in  2  valid byte count in the word (0 means 4). Bytes are taken from byte 0 upward.
- s_last  in  1  word is the final word of the frame.
- tab_addr  out  32  table address: {24'b0, index}.
- tab_rdata  in  32  table data (combinational read).
- m_valid  out  1  final CRC valid.
- m_ready  in  1  consumer accepts CRC.
- m_crc  out  32  final CRC.
- busy  out  1  high whenever state != IDLE or a frame is open.

Behaviour:
- Reset values:
  - s_ready=1, m_valid=0, m_crc=0, tab_addr=0, busy=0.
  - crc=INIT, sof=1, state=IDLE.
- Reset is asynchronous. Asserting it mid-frame or mid-DONE discards all progress.
- IDLE:
  - s_ready=1.
  - On accept: latch word, nbytes (0→4) and last; clear byte_idx; go to RUN.
  - If sof=1 at accept, load crc=INIT and clear sof.
- RUN:
  - s_ready=0.
  - Table index = crc[7:0] ^ word byte[byte_idx].
  - crc <= (crc >> 8) ^ tab_rdata, once per cycle.
  - byte_idx increments each cycle. When byte_idx == nbytes-1: go to DONE if last, otherwise go to IDLE.
- DONE:
  - m_valid=1 and m_crc = crc ^ XOR_OUT; both are registered and held stable until m_ready.
  - s_ready=0.
  - On m_ready: m_valid<=0, crc<=INIT, sof<=1, go to IDLE.
- tab_addr is 0 outside RUN.
- Latency:
  - A word with n bytes occupies 1 accept cycle plus n RUN cycles.
  - m_valid rises on the cycle after the last RUN cycle, i.e. n+1 cycles after the last-word accept edge.
- Boundaries:
  - s_bytes=0 means a full word of 4 bytes.
  - The block never drops a word. s_valid held while s_ready=0 is not consumed.
  - m_ready asserted while m_valid=0 is ignored.
  - A frame may be a single word with s_last=1.

Optional Feature:
- Macro: CRC_LUT_SEQ_REG_TAB_EN. It selects a registered-output table (1-cycle read latency).
- Defined:
  - RUN alternates ISSUE (drive tab_addr) and UPDATE (apply tab_rdata, advance byte_idx).
  - tab_addr is held stable across both cycles. Each byte costs 2 cycles; latency becomes 2n+1.
- Undefined: behaviour is exactly as described above.

Decomposition:
- Package crc_lut_pkg holds:
  - the state enum (IDLE, RUN, DONE; plus ISSUE/UPDATE sub-phase when the macro is defined);
  - CRC_W=32 and TAB_AW=8;
  - default INIT and XOR_OUT constants.
- No sub-module; the table stays external. Benches instantiate crctab_* as the golden table.

Test Plan:
1. INIT=0, XOR_OUT=0; one word s_data=32'h01, s_bytes=1, s_last=1 → tab_addr=1 in RUN; m_crc=32'h47f7cec1; m_valid 2 cycles after accept.
2. INIT=0, XOR_OUT=0; byte 0x80, s_last=1 → m_crc=32'h6e87f0b9. Repeat with byte 0xFF → 32'h8a1711fc.
3. Defaults INIT=XOR_OUT=FFFFFFFF; single byte 0xFF → index 0, crc=32'h00FFFFFF, m_crc=32'hFF000000.
4. INIT=0, XOR_OUT=0; one word s_data=32'h0001, s_bytes=2, s_last=1 → second index 0xC1; m_crc=32'h9c14bf31. The same bytes split across two 1-byte words give an identical result.
5. Back-pressure: hold m_ready=0 for 5 cycles in DONE → m_valid and m_crc stable, s_ready=0. A new frame is accepted only after the m_ready handshake, and it restarts from INIT.
6. Pulse rstn low during RUN of a 4-byte non-last word → outputs return to reset values immediately. The next frame's CRC matches the result obtained with no reset.
